// File: rtl/edge_pkg.sv
// Shared constants for the image-filter configuration slave: register offsets,
// AHB transfer encodings and the error-response FSM state type.
package edge_pkg;

  localparam logic [4:0] OFF_WIDTH       = 5'h00;
  localparam logic [4:0] OFF_HEIGHT      = 5'h04;
  localparam logic [4:0] OFF_READ_START  = 5'h08;
  localparam logic [4:0] OFF_WRITE_START = 5'h0C;
  localparam logic [4:0] OFF_FILTER      = 5'h10;
  localparam logic [4:0] OFF_CTRL        = 5'h14;
  localparam logic [4:0] OFF_STATUS      = 5'h18;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_READY = 2'd0;
  localparam state_t ST_ERR1  = 2'd1;
  localparam state_t ST_ERR2  = 2'd2;

endpackage

// File: rtl/config_slave.sv
// AHB-lite register slave holding image configuration and engine start/done handshake.
// Zero-wait OKAY for mapped transfers; two-cycle ERROR response otherwise (hready low one cycle).
module config_slave
  import edge_pkg::*;
#(
  parameter int BUSWIDTH  = 32,
  parameter int ADDR_LSBS = 8
) (
  input  logic                ahb_hclk,
  input  logic                rst,
  input  logic                ahb_hsel,
  input  logic [1:0]          ahb_htrans,
  input  logic                ahb_hwrite,
  input  logic [BUSWIDTH-1:0] ahb_haddr,
  input  logic [BUSWIDTH-1:0] ahb_hwdata,
  output logic [BUSWIDTH-1:0] ahb_hrdata,
  output logic                ahb_hready,
  output logic                ahb_hresp,
  output logic [BUSWIDTH-1:0] width,
  output logic [BUSWIDTH-1:0] height,
  output logic [BUSWIDTH-1:0] readStartAddress,
  output logic [BUSWIDTH-1:0] writeStartAddress,
  output logic                filterType,
  output logic                start_pulse,
  input  logic                engine_done,
  output logic                busy
);

  state_t                 state;
  logic                   done;
  logic                   dp_vld;
  logic [4:0]             dp_off;
  logic [ADDR_LSBS-1:0]   off;
  logic                   accept;
  logic                   bad_addr;
  logic                   unused_haddr;

  logic [BUSWIDTH-1:0]    width_nxt, height_nxt, rd_start_nxt, wr_start_nxt, rd_mux;
  logic                   filter_nxt, busy_nxt, done_nxt, start_go;

  assign off          = ahb_haddr[ADDR_LSBS-1:0];
  assign unused_haddr = ^ahb_haddr[BUSWIDTH-1:ADDR_LSBS];
  assign accept       = ahb_hsel && ahb_hready &&
                        ((ahb_htrans == HTRANS_NONSEQ) || (ahb_htrans == HTRANS_SEQ));
  assign bad_addr     = (off > ADDR_LSBS'(OFF_STATUS)) || (off[1:0] != 2'b00);

  assign ahb_hready = (state != ST_ERR1);
  assign ahb_hresp  = (state != ST_READY);

  // Post-write register image; reads sample it so a read right behind a write sees the new value.
  always_comb begin
    width_nxt    = width;
    height_nxt   = height;
    rd_start_nxt = readStartAddress;
    wr_start_nxt = writeStartAddress;
    filter_nxt   = filterType;
    busy_nxt     = busy;
    done_nxt     = done;
    start_go     = 1'b0;
    if (dp_vld) begin
      case (dp_off)
        OFF_WIDTH:       if (!busy) width_nxt    = ahb_hwdata;
        OFF_HEIGHT:      if (!busy) height_nxt   = ahb_hwdata;
        OFF_READ_START:  if (!busy) rd_start_nxt = ahb_hwdata;
        OFF_WRITE_START: if (!busy) wr_start_nxt = ahb_hwdata;
        OFF_FILTER:      if (!busy) filter_nxt   = ahb_hwdata[0];
        OFF_CTRL:        start_go = ahb_hwdata[0] && !busy;
        OFF_STATUS:      if (ahb_hwdata[1]) done_nxt = 1'b0;
        default: ;
      endcase
    end
    if (engine_done) begin
      busy_nxt = 1'b0;
      done_nxt = 1'b1;
    end
    if (start_go) busy_nxt = 1'b1;
  end

  always_comb begin
    rd_mux = '0;
    case (off[4:0])
      OFF_WIDTH:       rd_mux = width_nxt;
      OFF_HEIGHT:      rd_mux = height_nxt;
      OFF_READ_START:  rd_mux = rd_start_nxt;
      OFF_WRITE_START: rd_mux = wr_start_nxt;
      OFF_FILTER:      rd_mux[0] = filter_nxt;
      OFF_STATUS:      rd_mux[1:0] = {done_nxt, busy_nxt};
      default: ;
    endcase
  end

  always_ff @(posedge ahb_hclk) begin
    if (rst) begin
      state             <= ST_READY;
      dp_vld            <= 1'b0;
      dp_off            <= '0;
      ahb_hrdata        <= '0;
      width             <= '0;
      height            <= '0;
      readStartAddress  <= '0;
      writeStartAddress <= '0;
      filterType        <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      start_pulse       <= 1'b0;
    end else begin
      width             <= width_nxt;
      height            <= height_nxt;
      readStartAddress  <= rd_start_nxt;
      writeStartAddress <= wr_start_nxt;
      filterType        <= filter_nxt;
      busy              <= busy_nxt;
      done              <= done_nxt;
      start_pulse       <= start_go;
      dp_vld            <= accept && !bad_addr && ahb_hwrite;
      dp_off            <= off[4:0];
      if (accept && !ahb_hwrite) ahb_hrdata <= bad_addr ? '0 : rd_mux;
      // ERR2 accepting another bad transfer loops straight back to ERR1
      if (accept && bad_addr)  state <= ST_ERR1;
      else if (state == ST_ERR1) state <= ST_ERR2;
      else                     state <= ST_READY;
    end
  end

endmodule

// File: tb/tb_config_slave.sv
// Randomized and directed checks of config_slave against a transaction-level register model.
module tb_config_slave;
  import edge_pkg::*;

  logic        ahb_hclk = 1'b0;
  logic        rst;
  logic        ahb_hsel;
  logic [1:0]  ahb_htrans;
  logic        ahb_hwrite;
  logic [31:0] ahb_haddr;
  logic [31:0] ahb_hwdata;
  logic [31:0] ahb_hrdata;
  logic        ahb_hready;
  logic        ahb_hresp;
  logic [31:0] width, height, readStartAddress, writeStartAddress;
  logic        filterType, start_pulse, engine_done, busy;

  always #5 ahb_hclk = ~ahb_hclk;

  config_slave #(.BUSWIDTH(32), .ADDR_LSBS(8)) dut (
    .ahb_hclk(ahb_hclk), .rst(rst), .ahb_hsel(ahb_hsel), .ahb_htrans(ahb_htrans),
    .ahb_hwrite(ahb_hwrite), .ahb_haddr(ahb_haddr), .ahb_hwdata(ahb_hwdata),
    .ahb_hrdata(ahb_hrdata), .ahb_hready(ahb_hready), .ahb_hresp(ahb_hresp),
    .width(width), .height(height), .readStartAddress(readStartAddress),
    .writeStartAddress(writeStartAddress), .filterType(filterType),
    .start_pulse(start_pulse), .engine_done(engine_done), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: register file indexed by word offset, error-response countdown, pending write.
  logic [31:0] m_reg [0:4];
  logic        m_busy, m_done, m_pulse;
  int          m_errph;
  logic [31:0] m_rdata;
  logic        m_pw_vld;
  logic [7:0]  m_pw_off;
  logic [31:0] nxt_wdata = 32'h0;

  function automatic logic [31:0] m_read(input logic [7:0] o);
    int idx = int'(o) / 4;
    if (idx <= 4) return m_reg[idx];
    if (idx == 6) return {30'b0, m_done, m_busy};
    return 32'h0;
  endfunction

  task automatic model_update(input logic sel, input logic [1:0] tr, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic edone, input logic rs);
    logic acc, bad, start;
    logic [7:0] o;
    int idx;
    if (rs) begin
      for (int i = 0; i < 5; i++) m_reg[i] = 32'h0;
      m_busy = 0; m_done = 0; m_pulse = 0; m_errph = 0;
      m_rdata = 0; m_pw_vld = 0; m_pw_off = 0;
      return;
    end
    acc   = sel && tr[1] && (m_errph != 2);
    o     = addr[7:0];
    bad   = (o > 8'h18) || (o[1:0] != 2'b00);
    start = 0;
    if (m_pw_vld) begin
      idx = int'(m_pw_off) / 4;
      if (idx <= 4 && !m_busy) m_reg[idx] = (idx == 4) ? {31'b0, wd[0]} : wd;
      if (idx == 5 && wd[0] && !m_busy) start = 1;
      if (idx == 6 && wd[1]) m_done = 0;
    end
    if (edone) begin m_busy = 0; m_done = 1; end
    if (start) m_busy = 1;
    m_pulse = start;
    if (acc && !wr) m_rdata = bad ? 32'h0 : m_read(o);
    m_errph  = (acc && bad) ? 2 : (m_errph > 0 ? m_errph - 1 : 0);
    m_pw_vld = acc && !bad && wr;
    m_pw_off = o;
  endtask

  task automatic check_outputs();
    chk("hready", ahb_hready, m_errph != 2);
    chk("hresp", ahb_hresp, m_errph != 0);
    chk("hrdata", ahb_hrdata, m_rdata);
    chk("start_pulse", start_pulse, m_pulse);
    chk("busy", busy, m_busy);
    chk("width", width, m_reg[0]);
    chk("height", height, m_reg[1]);
    chk("read_start", readStartAddress, m_reg[2]);
    chk("write_start", writeStartAddress, m_reg[3]);
    chk("filter", filterType, m_reg[4][0]);
  endtask

  // One bus cycle: drive address phase plus data for the previous write, then check at negedge.
  task automatic step(input logic sel, input logic [1:0] tr, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic edone, input logic rs);
    ahb_hsel = sel; ahb_htrans = tr; ahb_hwrite = wr; ahb_haddr = addr;
    ahb_hwdata = nxt_wdata; engine_done = edone; rst = rs;
    model_update(sel, tr, wr, addr, nxt_wdata, edone, rs);
    nxt_wdata = wd;
    @(posedge ahb_hclk);
    @(negedge ahb_hclk);
    check_outputs();
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, HTRANS_NONSEQ, 1'b1, a, d, 1'b0, 1'b0);
  endtask
  task automatic rd_reg(input logic [31:0] a);
    step(1'b1, HTRANS_NONSEQ, 1'b0, a, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic idle(input logic edone);
    step(1'b0, HTRANS_IDLE, 1'b0, 32'h0, 32'h0, edone, 1'b0);
  endtask

  initial begin
    rst = 1; ahb_hsel = 0; ahb_htrans = HTRANS_IDLE; ahb_hwrite = 0;
    ahb_haddr = 0; ahb_hwdata = 0; engine_done = 0;
    @(negedge ahb_hclk);
    step(1'b0, HTRANS_IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step(1'b0, HTRANS_IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("rst_hready", ahb_hready, 32'h1);
    chk("rst_hresp", ahb_hresp, 32'h0);
    chk("rst_width", width, 32'h0);
    chk("rst_busy", busy, 32'h0);

    // Configuration write and read-back
    wr_reg(32'h00, 32'h151);
    wr_reg(32'h04, 32'h151);
    wr_reg(32'h08, 32'h1F4);
    wr_reg(32'h0C, 32'h157C);
    wr_reg(32'h10, 32'h1);
    rd_reg(32'h00); chk("rb_width", ahb_hrdata, 32'h151);
    rd_reg(32'h04); chk("rb_height", ahb_hrdata, 32'h151);
    rd_reg(32'h08); chk("rb_rstart", ahb_hrdata, 32'h1F4);
    rd_reg(32'h0C); chk("rb_wstart", ahb_hrdata, 32'h157C);
    rd_reg(32'h10); chk("rb_filter", ahb_hrdata, 32'h1);
    chk("rb_hresp", ahb_hresp, 32'h0);
    idle(1'b0);
    chk("cfg_width", width, 32'h151);
    chk("cfg_filter", filterType, 32'h1);

    // Start pulse and busy lockout
    wr_reg(32'h14, 32'h1);
    idle(1'b0); chk("start_hi", start_pulse, 32'h1); chk("busy_set", busy, 32'h1);
    idle(1'b0); chk("start_lo", start_pulse, 32'h0);
    wr_reg(32'h00, 32'h200);
    idle(1'b0); idle(1'b0); chk("busy_wr_ignored", width, 32'h151);
    wr_reg(32'h14, 32'h1);
    idle(1'b0); chk("no_restart", start_pulse, 32'h0);

    // Done handling and W1C
    idle(1'b1); chk("done_busy_clr", busy, 32'h0);
    rd_reg(32'h18); chk("status_done", ahb_hrdata, 32'h2);
    wr_reg(32'h18, 32'h2);
    rd_reg(32'h18); chk("status_w1c", ahb_hrdata, 32'h0);
    wr_reg(32'h18, 32'h2);
    idle(1'b1);
    rd_reg(32'h18); chk("done_wins", ahb_hrdata, 32'h2);

    // Error responses
    rd_reg(32'h20); chk("err1_hready", ahb_hready, 32'h0); chk("err1_hresp", ahb_hresp, 32'h1);
    idle(1'b0);     chk("err2_hready", ahb_hready, 32'h1); chk("err2_hresp", ahb_hresp, 32'h1);
    rd_reg(32'h02); chk("unal_hready", ahb_hready, 32'h0); chk("unal_hresp", ahb_hresp, 32'h1);
    idle(1'b0);
    rd_reg(32'h24); chk("loop_hready", ahb_hready, 32'h0); chk("loop_hresp", ahb_hresp, 32'h1);
    idle(1'b0); idle(1'b0); chk("err_recover", ahb_hresp, 32'h0);

    // Read directly behind a write
    wr_reg(32'h04, 32'hABC);
    rd_reg(32'h04); chk("fwd_height", ahb_hrdata, 32'hABC);
    idle(1'b0);

    // Reset during a data phase
    wr_reg(32'h0C, 32'h1234);
    step(1'b0, HTRANS_IDLE, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(1'b0);
    chk("rst_mid_wstart", writeStartAddress, 32'h0);
    chk("rst_mid_hready", ahb_hready, 32'h1);
    chk("rst_mid_hresp", ahb_hresp, 32'h0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] r, a, d;
      logic [7:0]  o;
      int k;
      r = $urandom;
      d = $urandom;
      k = $urandom_range(0, 9);
      if (k <= 6)      o = 8'(k * 4);
      else if (k == 7) o = 8'($urandom_range(0, 255));
      else             o = 8'(8'h1C + 4 * $urandom_range(0, 8));
      a = {r[31:8], o};
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           a, d, $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    end
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
